// File: rtl/gcd_lcm_cop.sv
// gcd_lcm_cop: iterative GCD/LCM coprocessor responder.
// Request word: A=[WIDTH-1:0], B=[2*WIDTH-1:WIDTH], op=[2*WIDTH] (0=GCD, 1=LCM).
// The result is returned zero-extended on copAns, and Done pulses for one cycle.
// Optional macro GCD_LCM_COP_LCM_EN enables the LCM engine. Without it, every
// request runs GCD and the op bit is ignored.
//
// state | meaning
// IDLE  | waiting for Start; operands latched on the Start edge
// GCD   | subtractive GCD, one step per cycle
// LCM   | additive LCM (multiples race until equal), one step per cycle
// DONE  | Done pulse cycle; copAns valid, returns to IDLE
module gcd_lcm_cop #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [31:0] WDFinal,
   output logic [31:0] copAns,
   output logic        Done,
   output logic        Busy
);

   localparam int RW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GCD  = 2'd1,
      S_LCM  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   assign in_a = WDFinal[WIDTH-1:0];
   assign in_b = WDFinal[RW-1:WIDTH];

`ifdef GCD_LCM_COP_LCM_EN
   logic [RW-1:0]    m1;
   logic [RW-1:0]    m2;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             unused_bits;
   assign unused_bits = ^WDFinal[31:RW+1];
`else
   logic             unused_bits;
   assign unused_bits = ^WDFinal[31:RW];
`endif

   // Controller FSM with registered Done/Busy/copAns and the compute datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         copAns <= '0;
         Done   <= 1'b0;
         Busy   <= 1'b0;
         a      <= '0;
         b      <= '0;
`ifdef GCD_LCM_COP_LCM_EN
         m1     <= '0;
         m2     <= '0;
         op_a   <= '0;
         op_b   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  Busy <= 1'b1;
`ifdef GCD_LCM_COP_LCM_EN
                  if (WDFinal[RW]) begin
                     m1    <= {{WIDTH{1'b0}}, in_a};
                     m2    <= {{WIDTH{1'b0}}, in_b};
                     op_a  <= in_a;
                     op_b  <= in_b;
                     state <= S_LCM;
                  end else begin
                     a     <= in_a;
                     b     <= in_b;
                     state <= S_GCD;
                  end
`else
                  a     <= in_a;
                  b     <= in_b;
                  state <= S_GCD;
`endif
               end
            end
            S_GCD: begin
               if (a == '0) begin
                  copAns <= {{(32-WIDTH){1'b0}}, b};
                  Done   <= 1'b1;
                  state  <= S_DONE;
               end else if (b == '0 || a == b) begin
                  copAns <= {{(32-WIDTH){1'b0}}, a};
                  Done   <= 1'b1;
                  state  <= S_DONE;
               end else if (a > b) begin
                  a <= a - b;
               end else begin
                  b <= b - a;
               end
            end
`ifdef GCD_LCM_COP_LCM_EN
            S_LCM: begin
               if (op_a == '0 || op_b == '0) begin
                  copAns <= '0;
                  Done   <= 1'b1;
                  state  <= S_DONE;
               end else if (m1 == m2) begin
                  copAns <= {{(32-RW){1'b0}}, m1};
                  Done   <= 1'b1;
                  state  <= S_DONE;
               end else if (m1 < m2) begin
                  m1 <= m1 + {{WIDTH{1'b0}}, op_a};
               end else begin
                  m2 <= m2 + {{WIDTH{1'b0}}, op_b};
               end
            end
`endif
            S_DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
